// File: rtl/cpu_intc.sv
// Multi-source interrupt controller: edge/level latching, masking and fixed
// lowest-index priority in front of a single CPU intr/int_ack handshake.
module cpu_intc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic              ie,
    input  logic              int_ack,
    output logic              intr,
    output logic [ID_W-1:0]   irq_id,
    input  logic              io_cs,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [1:0]        io_addr,
    input  logic [31:0]       io_din,
    output logic [31:0]       io_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N_SRC-1:0] pending, pend_nxt;
    logic [N_SRC-1:0] mask, edge_mode;
    logic [N_SRC-1:0] prev_src, edge_p0;
    logic [N_SRC-1:0] mask_eff, candidate, win_onehot, w1c, ack_clr;
    logic [ID_W-1:0]  win_id;
    logic             wr_en, rd_en, ack_take, eoi, cand_any;
    logic [31:0]      rd_data;
    logic             unused_din;

    function automatic logic [ID_W-1:0] lowest_index(input logic [N_SRC-1:0] v);
        lowest_index = ID_W'(N_SRC);
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = ID_W'(i);
        end
    endfunction

    assign unused_din = ^io_din;

    assign wr_en = io_cs & io_wr;
    assign rd_en = io_cs & io_rd;
    assign eoi   = wr_en && (io_addr == 2'd3);

    // A MASK write in flight is forwarded so that a same-cycle ACK or
    // withdrawal already sees the new mask.
    assign mask_eff   = (wr_en && io_addr == 2'd1) ? io_din[N_SRC-1:0] : mask;
    assign candidate  = pending & mask_eff;
    assign cand_any   = |candidate;
    assign win_onehot = candidate & (~candidate + N_SRC'(1));
    assign win_id     = lowest_index(candidate);

    assign ack_take = (state == REQ) && int_ack;
    assign w1c      = (wr_en && io_addr == 2'd0) ? (io_din[N_SRC-1:0] & edge_mode) : '0;
    assign ack_clr  = ack_take ? (win_onehot & edge_mode) : '0;

    // A new edge outranks any clear landing in the same cycle.
    assign pend_nxt = (edge_mode & (edge_p0 | (pending & ~w1c & ~ack_clr)))
                    | (~edge_mode & irq_src);

    always_comb begin
        rd_data = '0;
        case (io_addr)
            2'd0:    rd_data = 32'(pending);
            2'd1:    rd_data = 32'(mask);
            2'd2:    rd_data = 32'(edge_mode);
            default: rd_data = {state, 30'(irq_id)};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ie && cand_any) state_nxt = REQ;
            end
            REQ: begin
                if (ack_take)              state_nxt = SERVICE;
                else if (!ie || !cand_any) state_nxt = IDLE;
            end
            SERVICE: begin
                if (eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            intr  <= 1'b0;
        end else begin
            state <= state_nxt;
            intr  <= (state_nxt == REQ);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending   <= '0;
            mask      <= '0;
            edge_mode <= '0;
            prev_src  <= '0;
            edge_p0   <= '0;
            irq_id    <= '0;
            io_dout   <= '0;
        end else begin
            // Stage p0: registered rising-edge detect, then PENDING update.
            prev_src <= irq_src;
            edge_p0  <= irq_src & ~prev_src;
            pending  <= pend_nxt;
            if (wr_en && io_addr == 2'd1) mask      <= io_din[N_SRC-1:0];
            if (wr_en && io_addr == 2'd2) edge_mode <= io_din[N_SRC-1:0];
            if (ack_take) irq_id <= win_id;
            if (rd_en)    io_dout <= rd_data;
        end
    end

endmodule

// File: tb/tb_cpu_intc.sv
// Directed bench for cpu_intc: reset, edge/level servicing, masking,
// W1C/edge collision, spurious ACK and reset during service.
module tb_cpu_intc;

    localparam int N_SRC = 8;
    localparam int ID_W  = 6;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [N_SRC-1:0] irq_src;
    logic             ie, int_ack;
    logic             intr;
    logic [ID_W-1:0]  irq_id;
    logic             io_cs, io_rd, io_wr;
    logic [1:0]       io_addr;
    logic [31:0]      io_din, io_dout;

    int checks = 0;
    int errors = 0;

    cpu_intc #(.N_SRC(N_SRC), .ID_W(ID_W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .irq_src (irq_src),
        .ie      (ie),
        .int_ack (int_ack),
        .intr    (intr),
        .irq_id  (irq_id),
        .io_cs   (io_cs),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_din  (io_din),
        .io_dout (io_dout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic io_write(input logic [1:0] addr, input logic [31:0] data);
        io_cs = 1'b1; io_wr = 1'b1; io_addr = addr; io_din = data;
        tick();
        io_cs = 1'b0; io_wr = 1'b0; io_din = '0;
    endtask

    task automatic io_read(input logic [1:0] addr, output logic [31:0] data);
        io_cs = 1'b1; io_rd = 1'b1; io_addr = addr;
        tick();
        data = io_dout;
        io_cs = 1'b0; io_rd = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        sys_rst = 1'b1; irq_src = 8'hFF; ie = 1'b0; int_ack = 1'b0;
        io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_din = '0;

        // Reset
        tick(); tick();
        check("rst_intr", 32'(intr), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_dout", io_dout, 32'd0);
        sys_rst = 1'b0; irq_src = '0;
        for (int a = 0; a < 4; a++) begin
            io_read(2'(a), rd);
            check("rst_read", rd, 32'd0);
        end

        // Edge mode, two sources in the same cycle
        io_write(2'd2, 32'hFF);
        io_write(2'd1, 32'hFF);
        ie = 1'b1;
        irq_src = 8'h24;
        tick();
        irq_src = '0;
        check("edge_lat1", 32'(intr), 32'd0);
        tick();
        check("edge_lat2", 32'(intr), 32'd0);
        tick();
        check("edge_lat3", 32'(intr), 32'd1);
        ack();
        check("edge_id2", 32'(irq_id), 32'd2);
        check("edge_ack_intr", 32'(intr), 32'd0);
        io_read(2'd0, rd);
        check("edge_pend", rd, 32'h20);
        io_read(2'd3, rd);
        check("edge_active", rd, 32'h8000_0002);
        io_write(2'd3, 32'd0);
        check("eoi_idle", 32'(intr), 32'd0);
        tick();
        check("eoi_reassert", 32'(intr), 32'd1);
        ack();
        check("edge_id5", 32'(irq_id), 32'd5);
        io_write(2'd3, 32'd0);

        // Level mode
        io_write(2'd2, 32'h00);
        io_write(2'd1, 32'h08);
        irq_src = 8'h08;
        tick(); tick();
        check("lvl_intr", 32'(intr), 32'd1);
        ack();
        check("lvl_id3", 32'(irq_id), 32'd3);
        io_write(2'd3, 32'd0);
        tick();
        check("lvl_hold_reassert", 32'(intr), 32'd1);
        ack();
        irq_src = '0;
        tick();
        io_write(2'd3, 32'd0);
        tick(); tick();
        check("lvl_drop", 32'(intr), 32'd0);

        // Mask / ie withdrawal
        io_write(2'd2, 32'hFF);
        io_write(2'd1, 32'h02);
        irq_src = 8'h02;
        tick();
        irq_src = '0;
        tick(); tick();
        check("wd_req", 32'(intr), 32'd1);
        io_write(2'd1, 32'h00);
        check("wd_mask_drop", 32'(intr), 32'd0);
        io_read(2'd3, rd);
        check("wd_state_idle", rd, 32'h0000_0003);
        io_read(2'd0, rd);
        check("wd_pend_kept", rd, 32'h02);
        io_write(2'd1, 32'h02);
        tick();
        check("wd_unmask", 32'(intr), 32'd1);
        ie = 1'b0;
        tick(); tick();
        check("wd_ie_off", 32'(intr), 32'd0);

        // W1C colliding with a new edge on the same bit
        io_write(2'd1, 32'h10);
        irq_src = 8'h10;
        tick();
        io_write(2'd0, 32'h10);
        irq_src = '0;
        io_read(2'd0, rd);
        check("coll_set_wins", rd, 32'h12);
        io_write(2'd0, 32'h02);
        io_read(2'd0, rd);
        check("w1c_clear", rd, 32'h10);

        // Spurious: MASK cleared in the same cycle as int_ack
        ie = 1'b1;
        tick();
        check("spur_req", 32'(intr), 32'd1);
        io_cs = 1'b1; io_wr = 1'b1; io_addr = 2'd1; io_din = 32'h0; int_ack = 1'b1;
        tick();
        io_cs = 1'b0; io_wr = 1'b0; int_ack = 1'b0;
        check("spur_id", 32'(irq_id), 32'd8);
        check("spur_intr", 32'(intr), 32'd0);
        io_read(2'd3, rd);
        check("spur_active", rd, 32'h8000_0008);
        io_read(2'd0, rd);
        check("spur_pend", rd, 32'h10);
        io_write(2'd3, 32'd0);

        // Reset while in SERVICE
        io_write(2'd1, 32'h40);
        irq_src = 8'h40;
        tick();
        irq_src = '0;
        tick(); tick();
        check("rsv_req", 32'(intr), 32'd1);
        ack();
        check("rsv_id6", 32'(irq_id), 32'd6);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("rsv_id0", 32'(irq_id), 32'd0);
        check("rsv_intr", 32'(intr), 32'd0);
        io_read(2'd3, rd);
        check("rsv_active", rd, 32'd0);
        io_write(2'd2, 32'hFF);
        io_write(2'd1, 32'hFF);
        irq_src = 8'h02;
        tick();
        irq_src = '0;
        tick(); tick();
        check("rsv_new_req", 32'(intr), 32'd1);
        ack();
        check("rsv_new_id", 32'(irq_id), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
